// File: rtl/beacon_pkg.sv
// Shared tone-code constants and lock-FSM state encoding for the beacon
// tone counter and the beacon_lock block.
package beacon_pkg;

    localparam logic [1:0] FREQ_NONE = 2'b00;
    localparam logic [1:0] FREQ_500  = 2'b01;
    localparam logic [1:0] FREQ_1K   = 2'b10;
    localparam logic [1:0] FREQ_1K5  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONFIRM,
        ST_LOCKED,
        ST_HOLD
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/beacon_lock.sv
// Debounced beacon tone lock: confirms a stable tone code, holds it through short
// dropouts and drops it after a loss timeout. Optional BEACON_LOCK_CHG_EN adds change/lock_count.
module beacon_lock
    import beacon_pkg::*;
#(
    parameter int CONFIRM_CYCLES = 2_000_000,
    parameter int LOSS_CYCLES    = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] frequency,
    output logic [1:0] beacon,
    output logic       locked,
    output logic       lost
`ifdef BEACON_LOCK_CHG_EN
    ,
    output logic       change,
    output logic [7:0] lock_count
`endif
);

    localparam int CNT_W = $clog2(max_int(CONFIRM_CYCLES, LOSS_CYCLES) + 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       freq_q;
    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       beacon_q, beacon_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;
    logic             do_lock, do_drop;

    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which is what keeps this block from inferring latches.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        beacon_d = beacon_q;
        locked_d = locked_q;
        lost_d   = 1'b0;
        do_lock  = 1'b0;
        do_drop  = 1'b0;

        if (enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (freq_q != FREQ_NONE) begin
                        cand_d  = freq_q;
                        cnt_d   = CNT_ONE;
                        state_d = ST_CONFIRM;
                        do_lock = (CONFIRM_CYCLES == 1);
                    end
                end
                ST_CONFIRM: begin
                    if (freq_q == FREQ_NONE) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (freq_q == cand_q) begin
                        // Compare against threshold-1 so the counter never steps past it.
                        if (cnt_q >= CONFIRM_LAST) do_lock = 1'b1;
                        else                       cnt_d   = cnt_q + CNT_ONE;
                    end else begin
                        cand_d = freq_q;
                        cnt_d  = CNT_ONE;
                    end
                end
                ST_LOCKED: begin
                    if (freq_q != beacon_q) begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_ONE;
                        do_drop = (LOSS_CYCLES == 1);
                    end
                end
                ST_HOLD: begin
                    if (freq_q == beacon_q) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                    end else if (cnt_q >= LOSS_LAST) begin
                        do_drop = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (do_lock) begin
                state_d  = ST_LOCKED;
                beacon_d = cand_d;
                locked_d = 1'b1;
                cnt_d    = '0;
            end

            if (do_drop) begin
                beacon_d = FREQ_NONE;
                locked_d = 1'b0;
                lost_d   = 1'b1;
                cand_d   = freq_q;
                if (freq_q != FREQ_NONE) begin
                    state_d = ST_CONFIRM;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            freq_q   <= FREQ_NONE;
            cand_q   <= FREQ_NONE;
            cnt_q    <= '0;
            beacon_q <= FREQ_NONE;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= frequency;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            beacon_q <= beacon_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
        end
    end

    assign beacon = beacon_q;
    assign locked = locked_q;
    assign lost   = lost_q;

`ifdef BEACON_LOCK_CHG_EN
    logic       change_q;
    logic [7:0] lock_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            change_q     <= 1'b0;
            lock_count_q <= 8'd0;
        end else begin
            change_q <= (beacon_d != beacon_q);
            if (locked_d && !locked_q && (lock_count_q != 8'hFF)) begin
                lock_count_q <= lock_count_q + 8'd1;
            end
        end
    end

    assign change     = change_q;
    assign lock_count = lock_count_q;
`endif

endmodule

// File: tb/tb_beacon_lock.sv
// Scoreboard bench for beacon_lock with CONFIRM_CYCLES=8, LOSS_CYCLES=4; the
// change/lock_count scenario is compiled only when BEACON_LOCK_CHG_EN is defined.
module tb_beacon_lock;
    import beacon_pkg::*;

    localparam int CONF = 8;
    localparam int LOSS = 4;

    typedef struct packed {
        logic [1:0] beacon;
        logic       locked;
        logic       lost;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] frequency = 2'b00;
    logic [1:0] beacon;
    logic       locked;
    logic       lost;
`ifdef BEACON_LOCK_CHG_EN
    logic       change;
    logic [7:0] lock_count;
`endif

    exp_t sb[$];
    exp_t exp_v;
    int   n_vec = 0;
    int   n_err = 0;

    beacon_lock #(
        .CONFIRM_CYCLES(CONF),
        .LOSS_CYCLES   (LOSS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .frequency (frequency),
        .beacon    (beacon),
        .locked    (locked),
        .lost      (lost)
`ifdef BEACON_LOCK_CHG_EN
        ,
        .change    (change),
        .lock_count(lock_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic exp_t mk(input logic [1:0] b, input logic l, input logic p);
        mk = {b, l, p};
    endfunction

    // Drive one cycle of stimulus, queue what the outputs must be after the edge.
    task automatic apply(input logic [1:0] f, input logic en, input exp_t e);
        frequency = f;
        enable    = en;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        frequency = FREQ_NONE;
        enable    = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic reset_and_lock(input logic [1:0] code);
        do_reset();
        frequency = code;
        repeat (CONF + 1) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_and_lock(FREQ_1K);
        rst_n = 1'b0;
        apply(FREQ_1K5, 1'b0, mk(FREQ_NONE, 1'b0, 1'b0));
        rst_n = 1'b1;
        exp_v = sb.pop_front();
        n_vec++;
        if ({beacon, locked, lost} !== exp_v) begin
            n_err++;
            $display("FAIL reset got=%b/%b/%b want=%b/%b/%b", beacon, locked, lost,
                     exp_v.beacon, exp_v.locked, exp_v.lost);
        end
        for (int e = 1; e <= 2; e++) begin
            apply(FREQ_NONE, 1'b1, mk(FREQ_NONE, 1'b0, 1'b0));
            exp_v = sb.pop_front();
            n_vec++;
            if ({beacon, locked, lost} !== exp_v) begin
                n_err++;
                $display("FAIL reset_after e=%0d got=%b/%b/%b want=%b/%b/%b", e, beacon, locked,
                         lost, exp_v.beacon, exp_v.locked, exp_v.lost);
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        for (int e = 1; e <= 11; e++) begin
            apply(FREQ_1K, 1'b1, (e >= CONF + 1) ? mk(FREQ_1K, 1'b1, 1'b0)
                                                 : mk(FREQ_NONE, 1'b0, 1'b0));
            exp_v = sb.pop_front();
            n_vec++;
            if ({beacon, locked, lost} !== exp_v) begin
                n_err++;
                $display("FAIL lock e=%0d got=%b/%b/%b want=%b/%b/%b", e, beacon, locked, lost,
                         exp_v.beacon, exp_v.locked, exp_v.lost);
            end
        end
    endtask

    task automatic test_switch();
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            apply((e <= 5) ? FREQ_500 : FREQ_1K5, 1'b1,
                  (e >= 14) ? mk(FREQ_1K5, 1'b1, 1'b0) : mk(FREQ_NONE, 1'b0, 1'b0));
            exp_v = sb.pop_front();
            n_vec++;
            if ({beacon, locked, lost} !== exp_v) begin
                n_err++;
                $display("FAIL switch e=%0d got=%b/%b/%b want=%b/%b/%b", e, beacon, locked, lost,
                         exp_v.beacon, exp_v.locked, exp_v.lost);
            end
        end
    endtask

    task automatic test_dropout();
        reset_and_lock(FREQ_1K);
        for (int e = 1; e <= 11; e++) begin
            apply((e <= 3) ? FREQ_NONE : FREQ_1K, 1'b1, mk(FREQ_1K, 1'b1, 1'b0));
            exp_v = sb.pop_front();
            n_vec++;
            if ({beacon, locked, lost} !== exp_v) begin
                n_err++;
                $display("FAIL dropout e=%0d got=%b/%b/%b want=%b/%b/%b", e, beacon, locked, lost,
                         exp_v.beacon, exp_v.locked, exp_v.lost);
            end
        end
    endtask

    task automatic test_loss();
        reset_and_lock(FREQ_1K);
        for (int e = 1; e <= 13; e++) begin
            if (e < 5)       exp_v = mk(FREQ_1K, 1'b1, 1'b0);
            else if (e == 5) exp_v = mk(FREQ_NONE, 1'b0, 1'b1);
            else if (e < 12) exp_v = mk(FREQ_NONE, 1'b0, 1'b0);
            else             exp_v = mk(FREQ_1K5, 1'b1, 1'b0);
            apply(FREQ_1K5, 1'b1, exp_v);
            exp_v = sb.pop_front();
            n_vec++;
            if ({beacon, locked, lost} !== exp_v) begin
                n_err++;
                $display("FAIL loss e=%0d got=%b/%b/%b want=%b/%b/%b", e, beacon, locked, lost,
                         exp_v.beacon, exp_v.locked, exp_v.lost);
            end
        end
    endtask

    // Mixed mismatching codes still time out; the final zero sample drops to IDLE.
    task automatic test_mixed_loss();
        logic [1:0] seq [6];
        seq = '{FREQ_1K5, FREQ_500, FREQ_1K5, FREQ_NONE, FREQ_NONE, FREQ_NONE};
        reset_and_lock(FREQ_1K);
        for (int e = 1; e <= 6; e++) begin
            if (e < 5)       exp_v = mk(FREQ_1K, 1'b1, 1'b0);
            else if (e == 5) exp_v = mk(FREQ_NONE, 1'b0, 1'b1);
            else             exp_v = mk(FREQ_NONE, 1'b0, 1'b0);
            apply(seq[e-1], 1'b1, exp_v);
            exp_v = sb.pop_front();
            n_vec++;
            if ({beacon, locked, lost} !== exp_v) begin
                n_err++;
                $display("FAIL mixed_loss e=%0d got=%b/%b/%b want=%b/%b/%b", e, beacon, locked,
                         lost, exp_v.beacon, exp_v.locked, exp_v.lost);
            end
        end
        for (int e = 1; e <= CONF + 1; e++) begin
            apply(FREQ_1K, 1'b1, (e == CONF + 1) ? mk(FREQ_1K, 1'b1, 1'b0)
                                                 : mk(FREQ_NONE, 1'b0, 1'b0));
            exp_v = sb.pop_front();
            n_vec++;
            if ({beacon, locked, lost} !== exp_v) begin
                n_err++;
                $display("FAIL relock_idle e=%0d got=%b/%b/%b want=%b/%b/%b", e, beacon, locked,
                         lost, exp_v.beacon, exp_v.locked, exp_v.lost);
            end
        end
    endtask

    task automatic test_freeze();
        int bad;
        bad = 0;
        reset_and_lock(FREQ_500);
        for (int e = 1; e <= 100; e++) begin
            apply(FREQ_NONE, 1'b0, mk(FREQ_500, 1'b1, 1'b0));
            exp_v = sb.pop_front();
            n_vec++;
            if ({beacon, locked, lost} !== exp_v) begin
                n_err++;
                if (bad < 3)
                    $display("FAIL freeze e=%0d got=%b/%b/%b want=%b/%b/%b", e, beacon, locked,
                             lost, exp_v.beacon, exp_v.locked, exp_v.lost);
                bad++;
            end
        end
        for (int e = 1; e <= 6; e++) begin
            rst_n = (e == 3) ? 1'b0 : 1'b1;
            apply(FREQ_500, 1'b1, (e < 3) ? mk(FREQ_500, 1'b1, 1'b0)
                                          : mk(FREQ_NONE, 1'b0, 1'b0));
            rst_n = 1'b1;
            exp_v = sb.pop_front();
            n_vec++;
            if ({beacon, locked, lost} !== exp_v) begin
                n_err++;
                $display("FAIL freeze_reset e=%0d got=%b/%b/%b want=%b/%b/%b", e, beacon, locked,
                         lost, exp_v.beacon, exp_v.locked, exp_v.lost);
            end
        end
    endtask

`ifdef BEACON_LOCK_CHG_EN
    task automatic test_back_to_back();
        logic [1:0] prev, code;
        logic       exp_chg;
        int         bad;
        bad = 0;
        do_reset();
        for (int e = 1; e <= CONF + 1; e++) begin
            apply(FREQ_500, 1'b1, (e == CONF + 1) ? mk(FREQ_500, 1'b1, 1'b0)
                                                  : mk(FREQ_NONE, 1'b0, 1'b0));
            exp_v = sb.pop_front();
            n_vec++;
            if ({beacon, locked, lost, change} !== {exp_v, (e == CONF + 1)}) begin
                n_err++;
                $display("FAIL first_lock e=%0d got=%b/%b/%b/%b", e, beacon, locked, lost, change);
            end
        end
        n_vec++;
        if (lock_count !== 8'd1) begin
            n_err++;
            $display("FAIL lock_count_first got=%0d want=1", lock_count);
        end
        prev = FREQ_500;
        for (int i = 1; i < 300; i++) begin
            code = (prev == FREQ_500) ? FREQ_1K5 : FREQ_500;
            for (int e = 1; e <= 12; e++) begin
                if (e < 5)       exp_v = mk(prev, 1'b1, 1'b0);
                else if (e == 5) exp_v = mk(FREQ_NONE, 1'b0, 1'b1);
                else if (e < 12) exp_v = mk(FREQ_NONE, 1'b0, 1'b0);
                else             exp_v = mk(code, 1'b1, 1'b0);
                exp_chg = (e == 5) || (e == 12);
                apply(code, 1'b1, exp_v);
                exp_v = sb.pop_front();
                n_vec++;
                if ({beacon, locked, lost, change} !== {exp_v, exp_chg}) begin
                    n_err++;
                    if (bad < 3)
                        $display("FAIL b2b i=%0d e=%0d got=%b/%b/%b/%b want=%b/%b/%b/%b", i, e,
                                 beacon, locked, lost, change, exp_v.beacon, exp_v.locked,
                                 exp_v.lost, exp_chg);
                    bad++;
                end
            end
            prev = code;
        end
        n_vec++;
        if (lock_count !== 8'd255) begin
            n_err++;
            $display("FAIL lock_count_sat got=%0d want=255", lock_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_switch();
        test_dropout();
        test_loss();
        test_mixed_loss();
        test_freeze();
`ifdef BEACON_LOCK_CHG_EN
        test_back_to_back();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
